// File: rtl/sram_tp_burst_reader_pkg.sv
// Shared state encodings and width helper for the SRAM two-port burst read controller.
package sram_tp_burst_reader_pkg;

    localparam logic [1:0] SRAM_BRD_IDLE  = 2'd0;
    localparam logic [1:0] SRAM_BRD_ISSUE = 2'd1;
    localparam logic [1:0] SRAM_BRD_DRAIN = 2'd2;

    // Ceiling log2 with a floor of one bit so degenerate sizes still get a real signal.
    function automatic int func_log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_tp_burst_reader_fifo_sync_reg_based.sv
// Register-array FIFO with occupancy count; synchronous active-low reset plus a synchronous clear.
module fifo_sync_reg_based
    import sram_tp_burst_reader_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_WD = 8,
    localparam int CNT_WD = func_log2(DEPTH + 1),
    localparam int PTR_WD = func_log2(DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               pop_i,
    output logic [DATA_WD-1:0] dat_o,
    output logic [CNT_WD-1:0]  cnt_o
);

    localparam logic [PTR_WD-1:0] PTR_LAST = PTR_WD'(DEPTH - 1);

    logic [DATA_WD-1:0] mem_q [DEPTH];
    logic [PTR_WD-1:0]  wr_ptr_q;
    logic [PTR_WD-1:0]  rd_ptr_q;
    logic [CNT_WD-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_WD'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_WD'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CNT_WD'(1);
                2'b01:   cnt_q <= cnt_q - CNT_WD'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dat_o = mem_q[rd_ptr_q];
    assign cnt_o = cnt_q;

endmodule

// File: rtl/sram_tp_burst_reader.sv
// Burst read controller for the multi-bank two-port SRAM read port, credit-limited output buffer.
// Optional abort port enabled by defining SRAM_TP_BURST_READER_ABORT_EN.
module sram_tp_burst_reader
    import sram_tp_burst_reader_pkg::*;
#(
    parameter int KNOB_REGOUT  = 0,
    parameter int NUMB_BNK     = 4,
    parameter int SIZE         = 12,
    parameter int DATA_WD      = 16,
    parameter int BUF_DEPTH    = 4,
    localparam int NUMB_BNK_WD = func_log2(NUMB_BNK),
    localparam int SIZE_WD     = func_log2(SIZE),
    localparam int BUF_WD      = func_log2(BUF_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   cmd_val_i,
    output logic                   cmd_rdy_o,
    input  logic [NUMB_BNK_WD-1:0] cmd_idx_bnk_i,
    input  logic [SIZE_WD-1:0]     cmd_adr_i,
    input  logic [SIZE_WD-1:0]     cmd_num_i,
    output logic [NUMB_BNK_WD-1:0] cfg_idx_bnk_o,
    output logic                   rd_val_o,
    output logic [SIZE_WD-1:0]     rd_adr_o,
    input  logic                   rd_val_i,
    input  logic [DATA_WD-1:0]     rd_dat_i,
    output logic                   dat_val_o,
    input  logic                   dat_rdy_i,
    output logic [DATA_WD-1:0]     dat_dat_o,
    output logic                   dat_lst_o,
`ifdef SRAM_TP_BURST_READER_ABORT_EN
    input  logic                   abort_i,
`endif
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [SIZE_WD-1:0] ADR_LAST = SIZE_WD'(SIZE - 1);
    localparam logic [BUF_WD:0]    CREDITS  = BUF_DEPTH[BUF_WD:0];

    if (KNOB_REGOUT != 0 && KNOB_REGOUT != 1) begin : g_bad_knob
        $error("KNOB_REGOUT must be 0 or 1");
    end
    if (BUF_DEPTH < KNOB_REGOUT + 3) begin : g_small_buf
        $error("BUF_DEPTH must be at least SRAM latency + 2");
    end

    logic [1:0]             state_q, state_d;
    logic [NUMB_BNK_WD-1:0] bnk_q;
    logic [SIZE_WD-1:0]     adr_q, rem_q, num_q, pop_cnt_q;
    logic [BUF_WD-1:0]      out_cnt_q;
    logic [BUF_WD-1:0]      buf_cnt;
    logic [BUF_WD:0]        credit_used;
    logic                   accept, issue, ret_ok, push, pop, last_hs;
    logic                   abort_now, aborting;

`ifdef SRAM_TP_BURST_READER_ABORT_EN
    logic abort_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= (abort_q | abort_now) & (state_d != SRAM_BRD_IDLE);
        end
    end

    assign abort_now = abort_i & (state_q != SRAM_BRD_IDLE);
    assign aborting  = abort_q;
`else
    assign abort_now = 1'b0;
    assign aborting  = 1'b0;
`endif

    assign cmd_rdy_o = rstn & (state_q == SRAM_BRD_IDLE);
    assign accept    = cmd_val_i & cmd_rdy_o;
    assign busy_o    = (state_q != SRAM_BRD_IDLE);

    // Only returns we are actually waiting for count; anything else is left over from before a reset.
    assign ret_ok    = rd_val_i & (out_cnt_q != '0);
    assign push      = ret_ok & ~aborting & ~abort_now;
    assign dat_val_o = (buf_cnt != '0) & ~aborting & ~abort_now;
    assign pop       = dat_val_o & dat_rdy_i;
    assign dat_lst_o = dat_val_o & (pop_cnt_q == num_q);
    assign last_hs   = pop & dat_lst_o;
    assign done_o    = last_hs;

    // A word leaving the buffer this cycle hands its slot straight to the next read.
    assign credit_used = {1'b0, out_cnt_q} + {1'b0, buf_cnt} - {{BUF_WD{1'b0}}, pop};
    assign issue       = (state_q == SRAM_BRD_ISSUE) & ~abort_now & (credit_used < CREDITS);
    assign rd_val_o    = issue;
    assign rd_adr_o    = adr_q;
    assign cfg_idx_bnk_o = bnk_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            SRAM_BRD_IDLE:  if (accept) state_d = SRAM_BRD_ISSUE;
            SRAM_BRD_ISSUE: if (abort_now || (issue && rem_q == '0)) state_d = SRAM_BRD_DRAIN;
            SRAM_BRD_DRAIN: if ((aborting && out_cnt_q == '0) || last_hs) state_d = SRAM_BRD_IDLE;
            default:        state_d = SRAM_BRD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= SRAM_BRD_IDLE;
            bnk_q     <= '0;
            adr_q     <= '0;
            rem_q     <= '0;
            num_q     <= '0;
            pop_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                bnk_q     <= cmd_idx_bnk_i;
                adr_q     <= cmd_adr_i;
                rem_q     <= cmd_num_i;
                num_q     <= cmd_num_i;
                pop_cnt_q <= '0;
            end else begin
                if (issue) begin
                    adr_q <= (adr_q == ADR_LAST) ? '0 : adr_q + SIZE_WD'(1);
                    rem_q <= rem_q - SIZE_WD'(1);
                end
                if (pop) begin
                    pop_cnt_q <= pop_cnt_q + SIZE_WD'(1);
                end
            end
            case ({issue, ret_ok})
                2'b10:   out_cnt_q <= out_cnt_q + BUF_WD'(1);
                2'b01:   out_cnt_q <= out_cnt_q - BUF_WD'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    fifo_sync_reg_based #(
        .DEPTH   (BUF_DEPTH),
        .DATA_WD (DATA_WD)
    ) u_buf (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (abort_now),
        .push_i (push),
        .dat_i  (rd_dat_i),
        .pop_i  (pop),
        .dat_o  (dat_dat_o),
        .cnt_o  (buf_cnt)
    );

`ifdef SIM_KNOB_DBG
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(push && !pop && {1'b0, buf_cnt} == CREDITS))
                else $fatal(1, "read buffer overflow");
        end
    end
`endif

endmodule

// File: tb/tb_sram_tp_burst_reader.sv
// Directed bench for sram_tp_burst_reader with a behavioural SRAM read port of latency L.
module tb_sram_tp_burst_reader;

    localparam int REGOUT    = 0;
    localparam int L         = REGOUT + 1;
    localparam int NUMB_BNK  = 4;
    localparam int SIZE      = 12;
    localparam int DATA_WD   = 16;
    localparam int BUF_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_val_i = 1'b0;
    logic        cmd_rdy_o;
    logic [1:0]  cmd_idx_bnk_i = '0;
    logic [3:0]  cmd_adr_i = '0;
    logic [3:0]  cmd_num_i = '0;
    logic [1:0]  cfg_idx_bnk_o;
    logic        rd_val_o;
    logic [3:0]  rd_adr_o;
    logic        rd_val_i;
    logic [15:0] rd_dat_i;
    logic        dat_val_o;
    logic        dat_rdy_i = 1'b0;
    logic [15:0] dat_dat_o;
    logic        dat_lst_o;
    logic        busy_o;
    logic        done_o;
`ifdef SRAM_TP_BURST_READER_ABORT_EN
    logic        abort_i = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_tp_burst_reader #(
        .KNOB_REGOUT (REGOUT),
        .NUMB_BNK    (NUMB_BNK),
        .SIZE        (SIZE),
        .DATA_WD     (DATA_WD),
        .BUF_DEPTH   (BUF_DEPTH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_val_i     (cmd_val_i),
        .cmd_rdy_o     (cmd_rdy_o),
        .cmd_idx_bnk_i (cmd_idx_bnk_i),
        .cmd_adr_i     (cmd_adr_i),
        .cmd_num_i     (cmd_num_i),
        .cfg_idx_bnk_o (cfg_idx_bnk_o),
        .rd_val_o      (rd_val_o),
        .rd_adr_o      (rd_adr_o),
        .rd_val_i      (rd_val_i),
        .rd_dat_i      (rd_dat_i),
        .dat_val_o     (dat_val_o),
        .dat_rdy_i     (dat_rdy_i),
        .dat_dat_o     (dat_dat_o),
        .dat_lst_o     (dat_lst_o),
`ifdef SRAM_TP_BURST_READER_ABORT_EN
        .abort_i       (abort_i),
`endif
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    function automatic logic [15:0] mk_dat(input logic [1:0] b, input int a);
        logic [3:0] a4;
        a4 = a[3:0];
        return {4'hA, 2'b00, b, 4'h0, a4};
    endfunction

    // SRAM read port: fixed latency L, never reset, so stale returns survive a controller reset.
    logic [L-1:0] sram_v = '0;
    logic [15:0]  sram_d [L];
    always @(posedge clk) begin
        sram_v[0] <= rd_val_o;
        sram_d[0] <= mk_dat(cfg_idx_bnk_o, int'(rd_adr_o));
        for (int i = 1; i < L; i++) begin
            sram_v[i] <= sram_v[i-1];
            sram_d[i] <= sram_d[i-1];
        end
    end
    assign rd_val_i = sram_v[L-1];
    assign rd_dat_i = sram_d[L-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] bnk;
        logic [3:0] adr;
        logic [3:0] num;
        int         stall;          // cycles of dat_rdy_i=0 right after acceptance
        int         exp_done;       // cycles after acceptance edge, -1 = not timed
        int         exp_stall_iss;  // reads issued by the end of the stall, -1 = not checked
    } vec_t;

    task automatic run_burst(input vec_t v);
        int n, n_iss, n_pop, done_k;
        logic held, held_lst;
        logic [15:0] held_dat;
        n = int'(v.num) + 1;
        n_iss = 0; n_pop = 0; done_k = -1;
        held = 1'b0; held_lst = 1'b0; held_dat = '0;
        @(posedge clk); #1;
        cmd_val_i = 1'b1; cmd_idx_bnk_i = v.bnk; cmd_adr_i = v.adr; cmd_num_i = v.num;
        dat_rdy_i = (v.stall == 0);
        @(negedge clk);
        check("cmd_rdy_before", cmd_rdy_o, 1);
        @(posedge clk); #1;
        cmd_val_i = 1'b0;
        for (int k = 1; k <= 200 && done_k < 0; k++) begin
            dat_rdy_i = (k > v.stall);
            @(negedge clk);
            if (k == 1) begin
                check("busy", busy_o, 1);
                check("cfg_bnk", cfg_idx_bnk_o, v.bnk);
                check("first_issue", rd_val_o, 1);
            end
            if (held) begin
                check("hold_dat", dat_dat_o, held_dat);
                check("hold_lst", dat_lst_o, held_lst);
            end
            if (rd_val_o) begin
                check("rd_adr", rd_adr_o, (int'(v.adr) + n_iss) % SIZE);
                n_iss++;
            end
            if (dat_val_o && dat_rdy_i) begin
                check("dat", dat_dat_o, mk_dat(v.bnk, (int'(v.adr) + n_pop) % SIZE));
                check("lst", dat_lst_o, n_pop == n - 1);
                check("done", done_o, n_pop == n - 1);
                n_pop++;
                if (done_o) done_k = k;
            end else if (done_o) begin
                check("done_spurious", done_o, 0);
            end
            if (k == v.stall && v.exp_stall_iss >= 0) check("stall_iss", n_iss, v.exp_stall_iss);
            held = dat_val_o && !dat_rdy_i;
            held_dat = dat_dat_o;
            held_lst = dat_lst_o;
            @(posedge clk); #1;
        end
        if (v.exp_done >= 0) check("done_cyc", done_k, v.exp_done);
        else check("done_seen", done_k > 0, 1);
        check("n_issued", n_iss, n);
        check("n_words", n_pop, n);
        @(negedge clk);
        check("cmd_rdy_after", cmd_rdy_o, 1);
        $display("burst bnk=%0d adr=%0d num=%0d stall=%0d: issued=%0d words=%0d done_at=T+%0d",
                 v.bnk, v.adr, v.num, v.stall, n_iss, n_pop, done_k);
    endtask

    initial begin
        vec_t vecs [6];
        vec_t v;
        vecs[0] = '{bnk: 2'd1, adr: 4'd5,  num: 4'd3,  stall: 0,  exp_done: 6,  exp_stall_iss: -1};
        vecs[1] = '{bnk: 2'd2, adr: 4'd10, num: 4'd3,  stall: 0,  exp_done: 6,  exp_stall_iss: -1};
        vecs[2] = '{bnk: 2'd3, adr: 4'd0,  num: 4'd0,  stall: 0,  exp_done: 3,  exp_stall_iss: -1};
        vecs[3] = '{bnk: 2'd0, adr: 4'd7,  num: 4'd9,  stall: 20, exp_done: -1, exp_stall_iss: 4};
        vecs[4] = '{bnk: 2'd1, adr: 4'd11, num: 4'd11, stall: 0,  exp_done: 14, exp_stall_iss: -1};
        vecs[5] = '{bnk: 2'd2, adr: 4'd3,  num: 4'd5,  stall: 3,  exp_done: -1, exp_stall_iss: 3};

        // Reset state, checked while rstn is still low and once released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_rdy", cmd_rdy_o, 0);
        check("rst_rd_val", rd_val_o, 0);
        check("rst_dat_val", dat_val_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_cfg", cfg_idx_bnk_o, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rel_cmd_rdy", cmd_rdy_o, 1);

        for (int i = 0; i < 6; i++) run_burst(vecs[i]);

        // Reset mid-burst: the read issued just before reset returns afterwards and must be dropped.
        @(posedge clk); #1;
        cmd_val_i = 1'b1; cmd_idx_bnk_i = 2'd2; cmd_adr_i = 4'd4; cmd_num_i = 4'd7; dat_rdy_i = 1'b1;
        @(posedge clk); #1;
        cmd_val_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_cmd_rdy", cmd_rdy_o, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_rd_val", rd_val_o, 0);
        check("post_rst_dat_val", dat_val_o, 0);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_done", done_o, 0);
        check("post_rst_cfg", cfg_idx_bnk_o, 0);
        check("post_rst_cmd_rdy", cmd_rdy_o, 1);
        $display("reset mid-burst: stale return pending=%0d", rd_val_i);
        v = '{bnk: 2'd3, adr: 4'd9, num: 4'd4, stall: 0, exp_done: 7, exp_stall_iss: -1};
        run_burst(v);

`ifdef SRAM_TP_BURST_READER_ABORT_EN
        begin
            int n_iss, idle_k;
            n_iss = 0; idle_k = -1;
            @(posedge clk); #1;
            cmd_val_i = 1'b1; cmd_idx_bnk_i = 2'd1; cmd_adr_i = 4'd0; cmd_num_i = 4'd7; dat_rdy_i = 1'b1;
            @(posedge clk); #1;
            cmd_val_i = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                abort_i = (k == 3);
                @(negedge clk);
                if (rd_val_o) n_iss++;
                @(posedge clk); #1;
            end
            abort_i = 1'b0;
            for (int k = 4; k <= 24; k++) begin
                @(negedge clk);
                if (rd_val_o) n_iss++;
                check("abort_dat_val", dat_val_o, 0);
                check("abort_done", done_o, 0);
                if (cmd_rdy_o && idle_k < 0) idle_k = k;
                @(posedge clk); #1;
            end
            check("abort_issued", n_iss, 2);
            check("abort_idle_at", idle_k, 5);
            $display("abort burst: issued=%0d idle_at=T+%0d", n_iss, idle_k);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
